// File: rtl/pulse_seq_pkg.sv
// Shared types for the pulse transmitter job sequencer: FSM state encoding and
// the per-job transmitter configuration record.
package pulse_seq_pkg;

  localparam int IDX_W  = 7;
  localparam int LOOP_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    GAP  = 2'd3
  } state_e;

  // Program-window settings handed to the transmitter for one job.
  typedef struct packed {
    logic [IDX_W-1:0]  start_idx;
    logic [IDX_W-1:0]  end_idx;
    logic [IDX_W-1:0]  loopback_idx;
    logic [LOOP_W-1:0] loop_count;
  } job_cfg_t;

endpackage

// File: rtl/pulse_seq_job_fifo.sv
// Synchronous job FIFO with occupancy count, flush, and same-cycle push/pop.
// A push into a full FIFO is dropped; flush wins over push and pop.
module pulse_seq_job_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; an entry is never read before it
  // has been written, so its power-up contents are irrelevant.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/pulse_transmitter_job_sequencer.sv
// Hardware job scheduler in front of the pulse transmitter: queues jobs and
// launches them back-to-back. Define PULSE_SEQ_GAP_EN for per-job idle gaps.
module pulse_transmitter_job_sequencer
  import pulse_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int GAP_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [IDX_W-1:0]       job_start_idx,
  input  logic [IDX_W-1:0]       job_end_idx,
  input  logic [LOOP_W-1:0]      job_loop_count,
  input  logic [IDX_W-1:0]       job_loopback_idx,
  input  logic [GAP_W-1:0]       job_gap,
  input  logic                   abort,
  input  logic                   tx_done,
  output logic                   tx_run,
  output logic [IDX_W-1:0]       tx_start_idx,
  output logic [IDX_W-1:0]       tx_end_idx,
  output logic [IDX_W-1:0]       tx_loopback_idx,
  output logic [LOOP_W-1:0]      tx_loop_count,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [7:0]             jobs_done,
  output logic                   job_done,
  output logic                   irq,
  input  logic                   irq_clr
);

`ifdef PULSE_SEQ_GAP_EN
  typedef struct packed {
    logic [GAP_W-1:0] gap;
    job_cfg_t         cfg;
  } entry_t;
`else
  typedef struct packed {
    job_cfg_t cfg;
  } entry_t;
`endif

  state_e   state;
  state_e   state_d;
  entry_t   wr_entry;
  entry_t   rd_entry;
  job_cfg_t active;
  logic     fifo_full;
  logic     fifo_empty;
  logic     avail_q;
  logic     pop;
  logic     done;

`ifdef PULSE_SEQ_GAP_EN
  logic [GAP_W-1:0] active_gap;
  logic [GAP_W-1:0] gap_cnt;
`else
  logic unused_gap;
  assign unused_gap = ^job_gap;
`endif

  pulse_seq_job_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (abort),
    .push  (job_valid),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state;
    pop     = 1'b0;
    done    = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (avail_q && !fifo_empty) begin
            pop     = 1'b1;
            state_d = LOAD;
          end
        end
        LOAD: state_d = RUN;
        RUN: begin
          if (tx_done) begin
            done = 1'b1;
`ifdef PULSE_SEQ_GAP_EN
            state_d = (active_gap != '0) ? GAP : IDLE;
`else
            state_d = IDLE;
`endif
          end
        end
        GAP: begin
`ifdef PULSE_SEQ_GAP_EN
          if (gap_cnt <= GAP_W'(1)) state_d = IDLE;
`else
          state_d = IDLE;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    wr_entry                  = '0;
    wr_entry.cfg.start_idx    = job_start_idx;
    wr_entry.cfg.end_idx      = job_end_idx;
    wr_entry.cfg.loopback_idx = job_loopback_idx;
    wr_entry.cfg.loop_count   = job_loop_count;
`ifdef PULSE_SEQ_GAP_EN
    wr_entry.gap              = job_gap;
`endif
  end

  // A freshly written job becomes eligible for pop one cycle after its write;
  // queued jobs behind a running one are already eligible when it finishes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tx_run    <= 1'b0;
      avail_q   <= 1'b0;
      active    <= '0;
      job_done  <= 1'b0;
      jobs_done <= '0;
      irq       <= 1'b0;
    end else begin
      state    <= state_d;
      tx_run   <= (state_d == RUN);
      avail_q  <= !abort && (fifo_count != '0);
      job_done <= done;
      if (done) jobs_done <= jobs_done + 1'b1;
      if (pop)  active    <= rd_entry.cfg;
      if (done && fifo_empty && !(job_valid && job_ready)) irq <= 1'b1;
      else if (irq_clr)                                    irq <= 1'b0;
    end
  end

`ifdef PULSE_SEQ_GAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_gap <= '0;
      gap_cnt    <= '0;
    end else begin
      if (pop) active_gap <= rd_entry.gap;
      if (done)              gap_cnt <= active_gap;
      else if (state == GAP) gap_cnt <= gap_cnt - 1'b1;
    end
  end
`endif

  assign job_ready       = !fifo_full;
  assign busy            = (state != IDLE);
  assign tx_start_idx    = active.start_idx;
  assign tx_end_idx      = active.end_idx;
  assign tx_loopback_idx = active.loopback_idx;
  assign tx_loop_count   = active.loop_count;

endmodule

// File: tb/tb_pulse_transmitter_job_sequencer.sv
// Self-checking bench for pulse_transmitter_job_sequencer: directed vector
// table, multi-cycle sequences, then random traffic against a timeline model.
module tb_pulse_transmitter_job_sequencer;

  localparam int DEPTH = 4;
  localparam int GAP_W = 16;
  localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef PULSE_SEQ_GAP_EN
  localparam bit GAP_ON = 1'b1;
`else
  localparam bit GAP_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             job_valid, job_ready;
  logic [6:0]       job_start_idx, job_end_idx, job_loopback_idx;
  logic [7:0]       job_loop_count;
  logic [GAP_W-1:0] job_gap;
  logic             abort, tx_done, tx_run;
  logic [6:0]       tx_start_idx, tx_end_idx, tx_loopback_idx;
  logic [7:0]       tx_loop_count;
  logic             busy;
  logic [CNT_W-1:0] fifo_count;
  logic [7:0]       jobs_done;
  logic             job_done, irq, irq_clr;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  pulse_transmitter_job_sequencer #(.DEPTH(DEPTH), .GAP_W(GAP_W)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_start_idx(job_start_idx), .job_end_idx(job_end_idx),
    .job_loop_count(job_loop_count), .job_loopback_idx(job_loopback_idx),
    .job_gap(job_gap), .abort(abort), .tx_done(tx_done), .tx_run(tx_run),
    .tx_start_idx(tx_start_idx), .tx_end_idx(tx_end_idx),
    .tx_loopback_idx(tx_loopback_idx), .tx_loop_count(tx_loop_count),
    .busy(busy), .fifo_count(fifo_count), .jobs_done(jobs_done),
    .job_done(job_done), .irq(irq), .irq_clr(irq_clr)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    job_valid = 1'b0; abort = 1'b0; tx_done = 1'b0; irq_clr = 1'b0;
  endtask

  task automatic set_job(input int s, input int e, input int l, input int lb, input int g);
    job_start_idx = 7'(s); job_end_idx = 7'(e); job_loop_count = 8'(l);
    job_loopback_idx = 7'(lb); job_gap = GAP_W'(g);
  endtask

  task automatic push_job(input int s, input int e, input int l, input int lb, input int g);
    set_job(s, e, l, lb, g);
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic wait_run(input logic level, input int max, input string name);
    for (int i = 0; i < max && tx_run !== level; i++) tick();
    check(name, tx_run, level);
  endtask

  // Edges from the tx_done edge up to and including the next tx_run rise.
  task automatic measure_low(output int low);
    low = 0;
    do begin
      low++;
      tick();
    end while (tx_run !== 1'b1 && low < 64);
  endtask

  // ---------------- reference model (timeline of job events) ----------------
  typedef struct { int s; int e; int l; int lb; int g; int t; } mjob_t;
  mjob_t mq[$];
  mjob_t m_act;
  bit    m_have, m_jdone, m_irq;
  int    m_run_from, m_free_at, m_jobs;

  task automatic model_reset();
    mq.delete();
    m_act = '{0, 0, 0, 0, 0, 0};
    m_have = 0; m_jdone = 0; m_irq = 0;
    m_run_from = 0; m_free_at = 0; m_jobs = 0;
  endtask

  // Predicts the effect of the clock edge numbered n given the current inputs.
  task automatic model_edge(input int n);
    bit push_ok, done, pop;
    push_ok = job_valid && (mq.size() < DEPTH) && !abort;
    m_jdone = 0;
    if (abort) begin
      mq.delete();
      m_have = 0;
      m_free_at = n + 1;
      if (irq_clr) m_irq = 0;
    end else begin
      done = m_have && tx_done && (n >= m_run_from);
      pop  = !m_have && (n >= m_free_at) && (mq.size() > 0) && (mq[0].t <= n - 2);
      if (done) begin
        m_have = 0;
        m_free_at = n + 1 + (GAP_ON ? m_act.g : 0);
        m_jobs = (m_jobs + 1) % 256;
        m_jdone = 1;
      end
      if (done && mq.size() == 0 && !push_ok) m_irq = 1;
      else if (irq_clr) m_irq = 0;
      if (pop) begin
        m_act = mq.pop_front();
        m_have = 1;
        m_run_from = n + 2;
      end
      if (push_ok)
        mq.push_back('{int'(job_start_idx), int'(job_end_idx), int'(job_loop_count),
                       int'(job_loopback_idx), int'(job_gap), n});
    end
  endtask

  task automatic check_model();
    check("rnd tx_run",     tx_run,          m_have && (cyc >= m_run_from));
    check("rnd busy",       busy,            m_have || (m_free_at > cyc));
    check("rnd fifo_count", fifo_count,      mq.size());
    check("rnd job_ready",  job_ready,       mq.size() < DEPTH);
    check("rnd jobs_done",  jobs_done,       m_jobs);
    check("rnd job_done",   job_done,        m_jdone);
    check("rnd irq",        irq,             m_irq);
    check("rnd start_idx",  tx_start_idx,    m_act.s);
    check("rnd end_idx",    tx_end_idx,      m_act.e);
    check("rnd loop_count", tx_loop_count,   m_act.l);
    check("rnd loopback",   tx_loopback_idx, m_act.lb);
  endtask

  task automatic do_reset();
    idle_inputs();
    set_job(0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic valid, abrt, done, clr;
    int   s, e;
    logic run, bsy, jd, irq;
    int   cnt, jobs, st, en;
  } vec_t;

  vec_t vtab[14];
  int   bb_s[3]  = '{4, 20, 40};
  int   bb_e[3]  = '{10, 33, 90};
  int   bb_l[3]  = '{1, 7, 200};
  int   bb_lb[3] = '{5, 21, 77};

  initial begin
    int low;
    //           vld abt dn clr  s   e   run bsy jd irq cnt jobs st en
    vtab[0]  = '{1, 0, 0, 0,  0, 15,  0, 0, 0, 0, 1, 0, 0,  0};
    vtab[1]  = '{0, 0, 0, 0,  0,  0,  0, 0, 0, 0, 1, 0, 0,  0};
    vtab[2]  = '{0, 0, 0, 0,  0,  0,  0, 1, 0, 0, 0, 0, 0, 15};
    vtab[3]  = '{0, 0, 0, 0,  0,  0,  1, 1, 0, 0, 0, 0, 0, 15};
    vtab[4]  = '{0, 0, 0, 0,  0,  0,  1, 1, 0, 0, 0, 0, 0, 15};
    vtab[5]  = '{0, 0, 1, 0,  0,  0,  0, 0, 1, 1, 0, 1, 0, 15};
    vtab[6]  = '{0, 0, 0, 0,  0,  0,  0, 0, 0, 1, 0, 1, 0, 15};
    vtab[7]  = '{0, 0, 0, 1,  0,  0,  0, 0, 0, 0, 0, 1, 0, 15};
    vtab[8]  = '{0, 0, 1, 0,  0,  0,  0, 0, 0, 0, 0, 1, 0, 15};
    vtab[9]  = '{1, 0, 0, 0,  5,  9,  0, 0, 0, 0, 1, 1, 0, 15};
    vtab[10] = '{0, 0, 0, 0,  0,  0,  0, 0, 0, 0, 1, 1, 0, 15};
    vtab[11] = '{0, 0, 0, 0,  0,  0,  0, 1, 0, 0, 0, 1, 5,  9};
    vtab[12] = '{1, 1, 0, 0, 20, 30,  0, 0, 0, 0, 0, 1, 5,  9};
    vtab[13] = '{0, 0, 0, 0,  0,  0,  0, 0, 0, 0, 0, 1, 5,  9};

    do_reset();
    check("reset tx_run", tx_run, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset job_ready", job_ready, 1'b1);
    check("reset fifo_count", fifo_count, 0);
    check("reset irq", irq, 1'b0);

    foreach (vtab[i]) begin
      set_job(vtab[i].s, vtab[i].e, 2, 3, 0);
      job_valid = vtab[i].valid; abort = vtab[i].abrt;
      tx_done = vtab[i].done;    irq_clr = vtab[i].clr;
      tick();
      idle_inputs();
      check($sformatf("vec%0d tx_run", i),     tx_run,       vtab[i].run);
      check($sformatf("vec%0d busy", i),       busy,         vtab[i].bsy);
      check($sformatf("vec%0d job_done", i),   job_done,     vtab[i].jd);
      check($sformatf("vec%0d irq", i),        irq,          vtab[i].irq);
      check($sformatf("vec%0d fifo_count", i), fifo_count,   vtab[i].cnt);
      check($sformatf("vec%0d jobs_done", i),  jobs_done,    vtab[i].jobs);
      check($sformatf("vec%0d start_idx", i),  tx_start_idx, vtab[i].st);
      check($sformatf("vec%0d end_idx", i),    tx_end_idx,   vtab[i].en);
    end

    // Back-to-back: three zero-gap jobs, two low cycles between runs.
    do_reset();
    for (int k = 0; k < 3; k++) push_job(bb_s[k], bb_e[k], bb_l[k], bb_lb[k], 0);
    wait_run(1'b1, 10, "bb first rise");
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bb%0d start_idx", k),  tx_start_idx,    bb_s[k]);
      check($sformatf("bb%0d end_idx", k),    tx_end_idx,      bb_e[k]);
      check($sformatf("bb%0d loop_count", k), tx_loop_count,   bb_l[k]);
      check($sformatf("bb%0d loopback", k),   tx_loopback_idx, bb_lb[k]);
      tick();
      tick();
      pulse_done();
      check($sformatf("bb%0d tx_run off", k), tx_run, 1'b0);
      check($sformatf("bb%0d job_done", k),   job_done, 1'b1);
      check($sformatf("bb%0d jobs_done", k),  jobs_done, k + 1);
      check($sformatf("bb%0d irq", k),        irq, k == 2);
      if (k < 2) begin
        measure_low(low);
        check($sformatf("bb%0d low cycles", k), low, 2);
      end
    end

    // Full FIFO while a job runs, then abort with jobs queued.
    do_reset();
    push_job(1, 2, 3, 4, 0);
    wait_run(1'b1, 10, "full first rise");
    for (int k = 0; k < 5; k++) begin
      set_job(10 + k, 11 + k, 1, 0, 0);
      job_valid = 1'b1;
      check($sformatf("full job_ready before push%0d", k), job_ready, k < 4);
      tick();
    end
    job_valid = 1'b0;
    check("full fifo_count", fifo_count, 4);
    check("full job_ready", job_ready, 1'b0);
    check("full still running", tx_run, 1'b1);
    abort = 1'b1; tx_done = 1'b1; job_valid = 1'b1;
    tick();
    idle_inputs();
    check("abort tx_run", tx_run, 1'b0);
    check("abort fifo_count", fifo_count, 0);
    check("abort busy", busy, 1'b0);
    check("abort job_done", job_done, 1'b0);
    check("abort jobs_done", jobs_done, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("post-abort%0d job_done", k), job_done, 1'b0);
      check($sformatf("post-abort%0d tx_run", k), tx_run, 1'b0);
    end

    // Inter-job gap, then irq set/clear collision.
    do_reset();
    push_job(1, 2, 1, 0, 10);
    push_job(3, 4, 1, 0, 0);
    wait_run(1'b1, 10, "gap first rise");
    check("gap first start_idx", tx_start_idx, 1);
    tick();
    pulse_done();
    check("gap busy after done", busy, GAP_ON);
    check("gap irq with queued job", irq, 1'b0);
    measure_low(low);
    check("gap low cycles", low, GAP_ON ? 12 : 2);
    check("gap second start_idx", tx_start_idx, 3);
    tick();
    irq_clr = 1'b1;
    pulse_done();
    irq_clr = 1'b0;
    check("irq set beats clear", irq, 1'b1);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    check("irq cleared", irq, 1'b0);

    // Asynchronous reset between clock edges while running.
    do_reset();
    push_job(7, 8, 9, 6, 0);
    wait_run(1'b1, 10, "areset rise");
    #3 rst = 1'b1;
    #1;
    check("areset tx_run", tx_run, 1'b0);
    check("areset busy", busy, 1'b0);
    check("areset start_idx", tx_start_idx, 0);
    check("areset loop_count", tx_loop_count, 0);
    check("areset job_ready", job_ready, 1'b1);
    rst = 1'b0;
    model_reset();
    tick();
    pulse_done();
    check("spurious tx_done jobs_done", jobs_done, 0);
    check("spurious tx_done job_done", job_done, 1'b0);
    check("spurious tx_done busy", busy, 1'b0);

    // Randomized traffic against the timeline model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      set_job($urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 255),
              $urandom_range(0, 127), $urandom_range(0, 4));
      job_valid = ($urandom_range(0, 2) == 0);
      tx_done   = ($urandom_range(0, 3) == 0);
      irq_clr   = ($urandom_range(0, 7) == 0);
      abort     = ($urandom_range(0, 49) == 0);
      model_edge(cyc);
      tick();
      check_model();
    end
    idle_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
